// File: rtl/point_addition_pkg.sv
// Shared modular-arithmetic helpers for the elliptic-curve point adder.
// Helpers work on W-bit words; callers zero-extend narrower operands.
package point_addition_pkg;

    localparam int N = 10;
    localparam int W = 32;

    typedef logic [W-1:0] word_t;

    function automatic word_t mod_add(input word_t a, input word_t b, input word_t m);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return s[W-1:0];
    endfunction

    function automatic word_t mod_sub(input word_t a, input word_t b, input word_t m);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W]) begin
            d = d + {1'b0, m};
        end
        return d[W-1:0];
    endfunction

    function automatic word_t mod_mul(input word_t a, input word_t b, input word_t m);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return word_t'(prod % {{W{1'b0}}, m});
    endfunction

    // Division by two mod an odd m: odd values borrow one m to become even.
    function automatic word_t mod_half(input word_t a, input word_t m);
        return a[0] ? W'(({1'b0, a} + {1'b0, m}) >> 1) : (a >> 1);
    endfunction

endpackage

// File: rtl/point_addition_mod_inverse.sv
// Combinational modular inverse by binary extended Euclid, unrolled 2n times.
// Each step halves u*v, so 2n steps always reach u == 1 or v == 1 for coprime inputs.
module mod_inverse
    import point_addition_pkg::*;
#(
    parameter int n = N
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] p,
    output logic [n-1:0] inv
);

    localparam logic [n-1:0] ONE = {{(n-1){1'b0}}, 1'b1};

    logic [n-1:0] u;
    logic [n-1:0] v;
    logic [n-1:0] s;
    logic [n-1:0] t;

    // Invariants: s*a == u and t*a == v (mod p).
    always_comb begin
        u = a;
        v = p;
        s = ONE;
        t = '0;
        for (int i = 0; i < 2 * n; i++) begin
            if (u != ONE && v != ONE) begin
                if (!u[0]) begin
                    u = u >> 1;
                    s = n'(mod_half(word_t'(s), word_t'(p)));
                end else if (!v[0]) begin
                    v = v >> 1;
                    t = n'(mod_half(word_t'(t), word_t'(p)));
                end else if (u >= v) begin
                    u = (u - v) >> 1;
                    s = n'(mod_half(mod_sub(word_t'(s), word_t'(t), word_t'(p)), word_t'(p)));
                end else begin
                    v = (v - u) >> 1;
                    t = n'(mod_half(mod_sub(word_t'(t), word_t'(s), word_t'(p)), word_t'(p)));
                end
            end
        end
        inv = (u == ONE) ? s : t;
    end

endmodule

// File: rtl/point_addition.sv
// Affine elliptic-curve point adder R = P + Q over GF(p), one result per clock.
// x1 == x2 (doubling or P == -Q) is flagged and yields a zero result.
module point_addition
    import point_addition_pkg::*;
#(
    parameter int n = N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] p,
    input  logic [n-1:0] x1,
    input  logic [n-1:0] y1,
    input  logic [n-1:0] x2,
    input  logic [n-1:0] y2,
    output logic [n-1:0] x3,
    output logic [n-1:0] y3,
    output logic         flag
);

    logic [n-1:0] dx;
    logic [n-1:0] dy;
    logic [n-1:0] dx_inv;
    logic [n-1:0] lambda;
    logic [n-1:0] lambda_sq;
    logic [n-1:0] x3_next;
    logic [n-1:0] y3_next;
    logic         exceptional;

    assign dx = n'(mod_sub(word_t'(x2), word_t'(x1), word_t'(p)));
    assign dy = n'(mod_sub(word_t'(y2), word_t'(y1), word_t'(p)));

    mod_inverse #(.n(n)) u_inv (
        .a   (dx),
        .p   (p),
        .inv (dx_inv)
    );

    assign lambda    = n'(mod_mul(word_t'(dy), word_t'(dx_inv), word_t'(p)));
    assign lambda_sq = n'(mod_mul(word_t'(lambda), word_t'(lambda), word_t'(p)));
    assign x3_next   = n'(mod_sub(word_t'(lambda_sq),
                                  mod_add(word_t'(x1), word_t'(x2), word_t'(p)),
                                  word_t'(p)));
    assign y3_next   = n'(mod_sub(mod_mul(word_t'(lambda),
                                          mod_sub(word_t'(x1), word_t'(x3_next), word_t'(p)),
                                          word_t'(p)),
                                  word_t'(y1), word_t'(p)));

    assign exceptional = (x1 == x2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x3   <= '0;
            y3   <= '0;
            flag <= 1'b0;
        end else begin
            flag <= exceptional;
            x3   <= exceptional ? '0 : x3_next;
            y3   <= exceptional ? '0 : y3_next;
        end
    end

endmodule

// File: tb/tb_point_addition.sv
// Self-checking bench for point_addition: directed cases plus random vectors
// checked against an integer model using brute-force inverses.
module tb_point_addition;

    localparam int NB = 10;

    logic          clk;
    logic          reset;
    logic [NB-1:0] p;
    logic [NB-1:0] x1;
    logic [NB-1:0] y1;
    logic [NB-1:0] x2;
    logic [NB-1:0] y2;
    logic [NB-1:0] x3;
    logic [NB-1:0] y3;
    logic          flag;

    int vectors;
    int miscompares;

    logic [NB-1:0] exp_x3;
    logic [NB-1:0] exp_y3;
    logic          exp_flag;
    logic [NB-1:0] prev_x3;
    logic [NB-1:0] prev_y3;
    logic          prev_flag;

    int primes[10] = '{3, 5, 7, 17, 97, 251, 521, 769, 1009, 1021};

    point_addition #(.n(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .p     (p),
        .x1    (x1),
        .y1    (y1),
        .x2    (x2),
        .y2    (y2),
        .x3    (x3),
        .y3    (y3),
        .flag  (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int md(input int v, input int m);
        int r;
        r = v % m;
        if (r < 0) r += m;
        return r;
    endfunction

    function automatic int inv_mod(input int a, input int m);
        for (int i = 1; i < m; i++) begin
            if ((a * i) % m == 1) return i;
        end
        return 0;
    endfunction

    // Chord rule straight from the field formulas.
    task automatic model(input int pp, input int a1, input int b1, input int a2, input int b2);
        int lam;
        int rx;
        int ry;
        if (a1 == a2) begin
            exp_x3   = '0;
            exp_y3   = '0;
            exp_flag = 1'b1;
        end else begin
            lam      = md(md(b2 - b1, pp) * inv_mod(md(a2 - a1, pp), pp), pp);
            rx       = md(lam * lam - a1 - a2, pp);
            ry       = md(lam * (a1 - rx) - b1, pp);
            exp_x3   = NB'(rx);
            exp_y3   = NB'(ry);
            exp_flag = 1'b0;
        end
    endtask

    task automatic compare(input string tag, input logic [NB-1:0] ox, input logic [NB-1:0] oy,
                           input logic of, input logic [NB-1:0] ex, input logic [NB-1:0] ey,
                           input logic ef);
        vectors++;
        assert (ox === ex && oy === ey && of === ef)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed x3=%0d y3=%0d flag=%0b, expected x3=%0d y3=%0d flag=%0b",
                   tag, ox, oy, of, ex, ey, ef);
        end
    endtask

    task automatic apply_stimulus(input int pp, input int a1, input int b1, input int a2, input int b2);
        @(negedge clk);
        prev_x3   = exp_x3;
        prev_y3   = exp_y3;
        prev_flag = exp_flag;
        p  = NB'(pp);
        x1 = NB'(a1);
        y1 = NB'(b1);
        x2 = NB'(a2);
        y2 = NB'(b2);
        model(pp, a1, b1, a2, b2);
    endtask

    task automatic check_output(input string tag);
        @(posedge clk);
        #1;
        compare(tag, x3, y3, flag, exp_x3, exp_y3, exp_flag);
    endtask

    task automatic check_const(input string tag, input int ex, input int ey, input logic ef);
        @(posedge clk);
        #1;
        compare(tag, x3, y3, flag, NB'(ex), NB'(ey), ef);
    endtask

    initial begin
        int pp;
        int a1;
        int a2;
        vectors     = 0;
        miscompares = 0;
        exp_x3      = '0;
        exp_y3      = '0;
        exp_flag    = 1'b0;
        reset = 1'b0;
        p  = NB'(17);
        x1 = '0;
        y1 = '0;
        x2 = '0;
        y2 = '0;

        #3;
        compare("reset_state", x3, y3, flag, '0, '0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        apply_stimulus(17, 6, 3, 5, 1);
        check_const("p17_basic", 10, 6, 1'b0);
        apply_stimulus(17, 5, 1, 6, 3);
        check_const("commutative", 10, 6, 1'b0);
        apply_stimulus(17, 5, 1, 0, 6);
        check_const("p17_second", 13, 7, 1'b0);
        apply_stimulus(17, 5, 1, 5, 16);
        check_const("neg_point", 0, 0, 1'b1);
        apply_stimulus(17, 5, 1, 5, 1);
        check_const("same_point", 0, 0, 1'b1);

        // Back-to-back alternation; before each edge the previous result must still show.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) apply_stimulus(17, 6, 3, 5, 1);
            else            apply_stimulus(17, 5, 1, 0, 6);
            compare("pipe_hold", x3, y3, flag, prev_x3, prev_y3, prev_flag);
            check_output("pipe_new");
        end

        // Asynchronous reset between edges, then recovery on the first edge.
        apply_stimulus(17, 6, 3, 5, 1);
        check_output("pre_reset");
        #2;
        reset = 1'b0;
        #1;
        compare("async_reset", x3, y3, flag, '0, '0, 1'b0);
        @(negedge clk);
        compare("reset_held", x3, y3, flag, '0, '0, 1'b0);
        reset = 1'b1;
        apply_stimulus(17, 5, 1, 0, 6);
        check_const("post_reset", 13, 7, 1'b0);

        apply_stimulus(1021, 0, 1020, 1020, 0);
        check_output("p_max_edges");
        apply_stimulus(3, 0, 2, 2, 1);
        check_output("p_min");

        for (int i = 0; i < 300; i++) begin
            pp = primes[$urandom_range(0, 9)];
            a1 = int'($urandom_range(0, pp - 1));
            a2 = ($urandom_range(0, 7) == 0) ? a1 : int'($urandom_range(0, pp - 1));
            apply_stimulus(pp, a1, int'($urandom_range(0, pp - 1)), a2, int'($urandom_range(0, pp - 1)));
            check_output("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
